// File: rtl/sliced_logic_unit_pkg.sv
// Shared encodings for the slice-serial logic unit and the ALU decoder.
// Op codes are fixed by the ALU instruction format; state codes are local to the unit.
package sliced_logic_unit_pkg;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sliced_logic_unit_logic_slice.sv
// Combinational SLICE-bit four-function logic cell, time-shared across all slices.
import sliced_logic_unit_pkg::*;

module logic_slice #(
  parameter int SLICE = 4
) (
  input  logic [1:0]       i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_y
);

  always_comb begin
    case (logic_op_e'(i_op))
      LOGIC_AND: o_y = i_a & i_b;
      LOGIC_OR:  o_y = i_a | i_b;
      LOGIC_XOR: o_y = i_a ^ i_b;
      default:   o_y = ~(i_a | i_b);
    endcase
  end

endmodule

// File: rtl/sliced_logic_unit.sv
// Slice-serial AND/OR/XOR/NOR unit: one SLICE-bit slice per clock, LSB first,
// with a one-cycle done pulse and a zero flag captured on completion.
//
// state   | meaning
// IDLE    | waiting for start; result/zero hold the last completed operation
// RUN     | writing slice cnt of the result each edge
// DONE    | done pulse; result and zero valid
import sliced_logic_unit_pkg::*;

module sliced_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = cnt_width(N);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  logic [31:0]        w_base;
  logic [SLICE-1:0]   w_a_slice;
  logic [SLICE-1:0]   w_b_slice;
  logic [SLICE-1:0]   w_y;
  logic [WIDTH-1:0]   w_result_next;
  logic               w_last;

  assign w_base    = 32'(r_cnt) * 32'(SLICE);
  assign w_a_slice = r_a[w_base +: SLICE];
  assign w_b_slice = r_b[w_base +: SLICE];
  assign w_last    = (r_cnt == CNT_W'(N - 1));

  logic_slice #(.SLICE(SLICE)) u_slice (
    .i_op (r_op),
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .o_y  (w_y)
  );

  // Full-width view of the result after this edge's slice write, so the
  // zero flag sees the final slice on the same edge it lands.
  always_comb begin
    w_result_next = r_result;
    w_result_next[w_base +: SLICE] = w_y;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)  w_state_next = ST_DONE;
      default:              w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= LOGIC_AND;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_op     <= i_op;
            r_result <= '0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_result <= w_result_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) r_zero <= (w_result_next == '0);
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Scoreboard bench for sliced_logic_unit: default 32/4 instance plus an 8/2 instance.
module tb_sliced_logic_unit;
  import sliced_logic_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, busy, done, zero;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        start8, busy8, done8, zero8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, result8;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_cnt8 = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t        q32[$];
  exp_t        e32;
  logic [7:0]  q8[$];
  logic [7:0]  e8;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[4];

  sliced_logic_unit dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_zero   (zero)
  );

  sliced_logic_unit #(.WIDTH(8), .SLICE(2)) dut8 (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start8),
    .i_op     (op8),
    .i_a      (a8),
    .i_b      (b8),
    .o_busy   (busy8),
    .o_done   (done8),
    .o_result (result8),
    .o_zero   (zero8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q32.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else begin
        e32 = q32.pop_front();
        check("sb_result", result, e32.res);
        check("sb_zero", 32'(zero), 32'(e32.zero));
      end
    end
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) check("spurious_done8", 32'(done8), 32'd0);
      else begin
        e8 = q8.pop_front();
        check("sb_result8", 32'(result8), 32'(e8));
        check("sb_zero8", 32'(zero8), 32'(e8 == 8'h00));
      end
    end
  end

  // Drive a start during one cycle and queue its expected outcome.
  task automatic issue(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.res  = model(f, x, y);
    e.zero = (e.res == 32'h0);
    start = 1'b1; op = f; a = x; b = y;
    q32.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample from the current negedge (numbered start_cyc) until busy drops.
  task automatic wait_idle(input int start_cyc, output int done_at, output int busy_cyc);
    int cyc;
    cyc = start_cyc;
    done_at = -1;
    busy_cyc = 0;
    while (busy && cyc < 64) begin
      if (done && done_at < 0) done_at = cyc;
      busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_at, busy_cyc, cyc, dc0;
    logic [31:0] tmp;

    vecs[0] = '{2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[1] = '{2'b01, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[2] = '{2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 8-bit / 2-bit slice instance: NOR, N=4
    tmp = model(2'b11, 32'h0F, 32'h30);
    q8.push_back(tmp[7:0]);
    start8 = 1'b1; op8 = 2'b11; a8 = 8'h0F; b8 = 8'h30;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", 32'(cyc), 32'd5);
    check("w8_result", 32'(result8), 32'h000000C0);
    @(negedge clk);
    check("w8_idle", 32'(busy8), 32'd0);

    // Start while RUN must be dropped, not queued
    dc0 = done_cnt;
    issue(2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = '0; b = '0;
    @(negedge clk);
    start = 1'b0;
    wait_idle(4, done_at, busy_cyc);
    repeat (3) @(negedge clk);
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_dones", 32'(done_cnt - dc0), 32'd1);
    check("ign_result", result, 32'h0000FFFF);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(1, done_at, busy_cyc);
      check($sformatf("v%0d_latency", i), 32'(done_at), 32'd9);
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cyc), 32'd9);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      @(negedge clk);
    end

    // Reset mid-RUN discards the pending operation (zero was 1 before this)
    issue(2'b01, 32'h11110000, 32'h00002222);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q32.delete();
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd0);
    issue(2'b10, 32'hAAAAAAAA, 32'h55555555);
    wait_idle(1, done_at, busy_cyc);
    check("post_rst_latency", 32'(done_at), 32'd9);
    check("post_rst_result", result, 32'hFFFFFFFF);
    check("post_rst_zero", 32'(zero), 32'd0);
    @(negedge clk);

    // Reset wins over start on the same edge
    dc0 = done_cnt;
    reset = 1'b1; start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("rst_start_busy_late", 32'(busy), 32'd0);
    check("rst_start_dones", 32'(done_cnt - dc0), 32'd0);
    check("sb_drained", 32'(q32.size() + q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
